// File: rtl/cnn_frame_scheduler_if.sv
// Frame-request, stage-valid and result bundle between the host/pipeline and the CNN frame scheduler.
// Naming keeps the i_/o_ prefixes as seen from the scheduler.
interface cnn_frame_scheduler_if #(
   parameter int CLS_BW = 8,
   parameter int FC_BW  = 16
);
   logic              i_start;
   logic              o_start_ready;
   logic              o_feed_start;
   logic              i_conv1_valid;
   logic              i_pool_valid;
   logic              i_st2_valid;
   logic              i_cls_valid;
   logic [CLS_BW-1:0] i_cls_alpha;
   logic              o_busy;
   logic              o_done;
   logic [CLS_BW-1:0] o_alpha;
   logic              o_err;
   logic [1:0]        o_err_code;
   logic              i_err_clr;
   logic [FC_BW-1:0]  o_frame_cnt;

   modport master (
      output i_start, i_conv1_valid, i_pool_valid, i_st2_valid,
             i_cls_valid, i_cls_alpha, i_err_clr,
      input  o_start_ready, o_feed_start, o_busy, o_done, o_alpha,
             o_err, o_err_code, o_frame_cnt
   );

   modport slave (
      input  i_start, i_conv1_valid, i_pool_valid, i_st2_valid,
             i_cls_valid, i_cls_alpha, i_err_clr,
      output o_start_ready, o_feed_start, o_busy, o_done, o_alpha,
             o_err, o_err_code, o_frame_cnt
   );
endinterface

// File: rtl/cnn_frame_scheduler.sv
// Frame-level sequencer for the Braille CNN pipeline: start handshake, per-stage
// valid-count audit, classifier result latch, one-deep start queue and watchdog.
//
// state | meaning
// IDLE  | waiting for a frame request
// FEED  | one cycle: feeder start pulse, counters and watchdog cleared
// RUN   | counting stage valids, waiting for the classifier
// DONE  | one cycle: done pulse, frame counter already bumped
// ERR   | sticky error, waits for i_err_clr
module cnn_frame_scheduler #(
   parameter int CONV1_CNT = 576,
   parameter int POOL_CNT  = 144,
   parameter int ST2_CNT   = 64,
   parameter int TIMEOUT   = 4096,
   parameter int CLS_BW    = 8,
   parameter int FC_BW     = 16
) (
   input logic                  clk,
   input logic                  reset_n,
   cnn_frame_scheduler_if.slave bus
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_FEED = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   localparam int C1W = $clog2(CONV1_CNT + 1);
   localparam int PLW = $clog2(POOL_CNT + 1);
   localparam int S2W = $clog2(ST2_CNT + 1);
   localparam int WDW = $clog2(TIMEOUT + 1);

   logic [2:0]        state;
   logic              pend;
   logic [C1W-1:0]    c1_q;
   logic [PLW-1:0]    pl_q;
   logic [S2W-1:0]    s2_q;
   logic [WDW-1:0]    wd_q;
   logic [CLS_BW-1:0] alpha_q;
   logic [1:0]        code_q;
   logic [FC_BW-1:0]  fcnt_q;

   logic              ready;
   logic              start_acc;
   logic              any_v;
   logic              ovf;
   logic              complete;
   logic              tmo;
   logic [C1W:0]      c1_sum;
   logic [PLW:0]      pl_sum;
   logic [S2W:0]      s2_sum;

   assign ready     = !pend && (state != S_ERR);
   assign start_acc = bus.i_start && ready;
   assign any_v     = bus.i_conv1_valid || bus.i_pool_valid || bus.i_st2_valid;

   // sums are one bit wider so a pulse on a full counter cannot alias to a match
   assign c1_sum = {1'b0, c1_q} + (C1W+1)'(bus.i_conv1_valid);
   assign pl_sum = {1'b0, pl_q} + (PLW+1)'(bus.i_pool_valid);
   assign s2_sum = {1'b0, s2_q} + (S2W+1)'(bus.i_st2_valid);

   assign complete = (c1_sum == (C1W+1)'(CONV1_CNT)) &&
                     (pl_sum == (PLW+1)'(POOL_CNT)) &&
                     (s2_sum == (S2W+1)'(ST2_CNT));

   assign ovf = (bus.i_conv1_valid && (c1_q == C1W'(CONV1_CNT))) ||
                (bus.i_pool_valid  && (pl_q == PLW'(POOL_CNT)))  ||
                (bus.i_st2_valid   && (s2_q == S2W'(ST2_CNT)));

   assign tmo = !any_v && (wd_q == WDW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         pend    <= 1'b0;
         c1_q    <= '0;
         pl_q    <= '0;
         s2_q    <= '0;
         wd_q    <= '0;
         alpha_q <= '0;
         code_q  <= '0;
         fcnt_q  <= '0;
      end else begin
         case (state)
            S_IDLE: if (start_acc) state <= S_FEED;
            S_FEED: begin
               c1_q  <= '0;
               pl_q  <= '0;
               s2_q  <= '0;
               wd_q  <= '0;
               state <= S_RUN;
            end
            S_RUN: begin
               c1_q <= c1_sum[C1W-1:0];
               pl_q <= pl_sum[PLW-1:0];
               s2_q <= s2_sum[S2W-1:0];
               wd_q <= any_v ? '0 : wd_q + WDW'(1);
               if (ovf) begin
                  state  <= S_ERR;
                  code_q <= 2'd2;
               end else if (bus.i_cls_valid && !complete) begin
                  state  <= S_ERR;
                  code_q <= 2'd1;
               end else if (bus.i_cls_valid) begin
                  state   <= S_DONE;
                  alpha_q <= bus.i_cls_alpha;
                  fcnt_q  <= fcnt_q + FC_BW'(1);
               end else if (tmo) begin
                  state  <= S_ERR;
                  code_q <= 2'd3;
               end
            end
            S_DONE: state <= (pend || start_acc) ? S_FEED : S_IDLE;
            S_ERR: begin
               if (bus.i_err_clr) begin
                  state  <= S_IDLE;
                  code_q <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase

         // one-deep queue: DONE consumes it, ERR discards it
         if ((state == S_ERR) || (state == S_DONE))
            pend <= 1'b0;
         else if (start_acc && (state != S_IDLE))
            pend <= 1'b1;
      end
   end

   assign bus.o_start_ready = ready;
   assign bus.o_feed_start  = (state == S_FEED);
   assign bus.o_busy        = (state == S_FEED) || (state == S_RUN) || (state == S_DONE);
   assign bus.o_done        = (state == S_DONE);
   assign bus.o_err         = (state == S_ERR);
   assign bus.o_err_code    = code_q;
   assign bus.o_alpha       = alpha_q;
   assign bus.o_frame_cnt   = fcnt_q;
endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// Bench for cnn_frame_scheduler: table vectors and directed frames on a full-size
// instance, random traffic against a behavioural model on a shrunken instance.
module tb_cnn_frame_scheduler;
   logic clk;
   logic rst_n_a;
   logic rst_n_b;
   int   vec_n;
   int   miscmp;

   localparam int B_TGT0 = 5;
   localparam int B_TGT1 = 3;
   localparam int B_TGT2 = 2;
   localparam int B_TO   = 12;

   cnn_frame_scheduler_if #(.CLS_BW(8), .FC_BW(16)) ifa ();
   cnn_frame_scheduler_if #(.CLS_BW(8), .FC_BW(2))  ifb ();

   cnn_frame_scheduler #(.CLS_BW(8), .FC_BW(16)) dut_a (
      .clk(clk), .reset_n(rst_n_a), .bus(ifa)
   );

   cnn_frame_scheduler #(
      .CONV1_CNT(B_TGT0), .POOL_CNT(B_TGT1), .ST2_CNT(B_TGT2),
      .TIMEOUT(B_TO), .CLS_BW(8), .FC_BW(2)
   ) dut_b (
      .clk(clk), .reset_n(rst_n_b), .bus(ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_n++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- full-size instance helpers ----------------
   task automatic a_start();
      ifa.i_start = 1'b1;
      cyc();
      ifa.i_start = 1'b0;
      cyc();
   endtask

   task automatic a_pulses(input int n1, input int n2, input int n3);
      int mx;
      mx = (n1 > n2) ? n1 : n2;
      mx = (mx > n3) ? mx : n3;
      for (int i = 0; i < mx; i++) begin
         ifa.i_conv1_valid = (i < n1);
         ifa.i_pool_valid  = (i < n2);
         ifa.i_st2_valid   = (i < n3);
         cyc();
      end
      ifa.i_conv1_valid = 1'b0;
      ifa.i_pool_valid  = 1'b0;
      ifa.i_st2_valid   = 1'b0;
   endtask

   task automatic a_cls(input logic [7:0] al);
      ifa.i_cls_valid = 1'b1;
      ifa.i_cls_alpha = al;
      cyc();
      ifa.i_cls_valid = 1'b0;
   endtask

   task automatic a_clr();
      ifa.i_err_clr = 1'b1;
      cyc();
      ifa.i_err_clr = 1'b0;
   endtask

   task automatic b_frame(input logic [7:0] al);
      ifb.i_start = 1'b1;
      cyc();
      ifb.i_start = 1'b0;
      cyc();
      for (int i = 0; i < B_TGT0; i++) begin
         ifb.i_conv1_valid = 1'b1;
         ifb.i_pool_valid  = (i < B_TGT1);
         ifb.i_st2_valid   = (i < B_TGT2);
         cyc();
      end
      ifb.i_conv1_valid = 1'b0;
      ifb.i_pool_valid  = 1'b0;
      ifb.i_st2_valid   = 1'b0;
      ifb.i_cls_valid   = 1'b1;
      ifb.i_cls_alpha   = al;
      cyc();
      ifb.i_cls_valid   = 1'b0;
   endtask

   // ---------------- behavioural reference for the small instance ----------------
   // phase: 0 idle, 1 feed, 2 run, 3 done, 4 error
   int         m_ph;
   bit         m_pend;
   int         m_cnt[3];
   int         m_idle;
   int         m_code;
   int         m_alpha;
   int         m_frames;
   int         m_tgt[3];

   function automatic logic [16:0] model_out();
      logic [16:0] r;
      r = {(!m_pend && m_ph != 4), (m_ph == 1), (m_ph >= 1 && m_ph <= 3), (m_ph == 3),
           (m_ph == 4), 2'(m_code), 8'(m_alpha), 2'(m_frames)};
      return r;
   endfunction

   task automatic model_step(input logic rb, input logic st, input logic [2:0] v,
                             input logic cl, input logic [7:0] al, input logic clr);
      bit rdy, acc, ovf, comp, any;
      rdy = !m_pend && (m_ph != 4);
      acc = st && rdy;
      if (!rb) begin
         m_ph = 0; m_pend = 0; m_idle = 0; m_code = 0; m_alpha = 0; m_frames = 0;
         foreach (m_cnt[k]) m_cnt[k] = 0;
         return;
      end
      case (m_ph)
         0: if (acc) m_ph = 1;
         1: begin
            foreach (m_cnt[k]) m_cnt[k] = 0;
            m_idle = 0;
            if (acc) m_pend = 1;
            m_ph = 2;
         end
         2: begin
            ovf = 0; comp = 1; any = |v;
            for (int k = 0; k < 3; k++) begin
               if (v[k] && m_cnt[k] == m_tgt[k]) ovf = 1;
               if (m_cnt[k] + int'(v[k]) != m_tgt[k]) comp = 0;
            end
            if (acc) m_pend = 1;
            if (ovf) begin m_ph = 4; m_code = 2; end
            else if (cl && !comp) begin m_ph = 4; m_code = 1; end
            else if (cl) begin m_ph = 3; m_alpha = al; m_frames = (m_frames + 1) % 4; end
            else if (!any && m_idle + 1 == B_TO) begin m_ph = 4; m_code = 3; end
            for (int k = 0; k < 3; k++) m_cnt[k] += int'(v[k]);
            m_idle = any ? 0 : m_idle + 1;
         end
         3: begin
            m_ph = (m_pend || acc) ? 1 : 0;
            m_pend = 0;
         end
         default: begin
            m_pend = 0;
            if (clr) begin m_ph = 0; m_code = 0; end
         end
      endcase
   endtask

   // ---------------- table vectors ----------------
   typedef struct packed {
      logic       start;
      logic       clr;
      logic       cls;
      logic       ready;
      logic       feed;
      logic       busy;
      logic       err;
      logic [1:0] code;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [2:0]  rv;
      logic        rst, st, cl, clr;
      logic [7:0]  al;
      logic [16:0] act;
      bit          full;

      vec_n = 0;
      miscmp = 0;
      m_tgt[0] = B_TGT0; m_tgt[1] = B_TGT1; m_tgt[2] = B_TGT2;

      //             start clr cls  ready feed busy err code
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};

      ifa.i_start = 0; ifa.i_conv1_valid = 0; ifa.i_pool_valid = 0; ifa.i_st2_valid = 0;
      ifa.i_cls_valid = 0; ifa.i_cls_alpha = 0; ifa.i_err_clr = 0;
      ifb.i_start = 0; ifb.i_conv1_valid = 0; ifb.i_pool_valid = 0; ifb.i_st2_valid = 0;
      ifb.i_cls_valid = 0; ifb.i_cls_alpha = 0; ifb.i_err_clr = 0;
      rst_n_a = 0;
      rst_n_b = 0;
      cyc();
      cyc();

      // reset state
      check("rst_ready", 32'(ifa.o_start_ready), 32'd1);
      check("rst_outs", 32'({ifa.o_feed_start, ifa.o_busy, ifa.o_done, ifa.o_err, ifa.o_err_code}), 32'd0);
      check("rst_alpha", 32'(ifa.o_alpha), 32'd0);
      check("rst_frames", 32'(ifa.o_frame_cnt), 32'd0);
      rst_n_a = 1;
      cyc();

      for (int r = 0; r < 7; r++) begin
         ifa.i_start = tbl[r].start;
         ifa.i_err_clr = tbl[r].clr;
         ifa.i_cls_valid = tbl[r].cls;
         cyc();
         check($sformatf("table_row%0d", r),
               32'({ifa.o_start_ready, ifa.o_feed_start, ifa.o_busy, ifa.o_err, ifa.o_err_code}),
               32'({tbl[r].ready, tbl[r].feed, tbl[r].busy, tbl[r].err, tbl[r].code}));
      end
      ifa.i_start = 0; ifa.i_err_clr = 0; ifa.i_cls_valid = 0;
      rst_n_a = 0;
      cyc();
      rst_n_a = 1;

      // nominal frame
      ifa.i_start = 1;
      cyc();
      ifa.i_start = 0;
      check("nom_feed_pulse", 32'({ifa.o_feed_start, ifa.o_busy}), 32'b11);
      cyc();
      check("nom_feed_gone", 32'(ifa.o_feed_start), 32'd0);
      a_pulses(575, 144, 64);
      check("nom_busy_run", 32'({ifa.o_busy, ifa.o_done, ifa.o_err}), 32'b100);
      a_pulses(1, 0, 0);
      a_cls(8'h41);
      check("nom_done", 32'(ifa.o_done), 32'd1);
      check("nom_alpha", 32'(ifa.o_alpha), 32'h41);
      check("nom_frames", 32'(ifa.o_frame_cnt), 32'd1);
      cyc();
      check("nom_idle", 32'({ifa.o_done, ifa.o_busy, ifa.o_start_ready}), 32'b001);

      // queued frame
      a_start();
      ifa.i_start = 1;
      cyc();
      ifa.i_start = 0;
      check("q_ready_low", 32'(ifa.o_start_ready), 32'd0);
      a_pulses(576, 144, 64);
      a_cls(8'h42);
      check("q_done", 32'({ifa.o_done, ifa.o_feed_start}), 32'b10);
      check("q_alpha", 32'(ifa.o_alpha), 32'h42);
      check("q_frames", 32'(ifa.o_frame_cnt), 32'd2);
      cyc();
      check("q_feed_after_done", 32'({ifa.o_done, ifa.o_feed_start}), 32'b01);
      cyc();

      // early classifier on the queued frame
      a_pulses(575, 144, 64);
      a_cls(8'h55);
      check("early_err", 32'({ifa.o_err, ifa.o_err_code, ifa.o_done}), 32'b1010);
      check("early_alpha_kept", 32'(ifa.o_alpha), 32'h42);
      check("early_frames_kept", 32'(ifa.o_frame_cnt), 32'd2);
      a_clr();
      check("early_clr", 32'({ifa.o_err, ifa.o_err_code, ifa.o_start_ready}), 32'b0001);

      // overflow, alone and coincident with an early classifier
      a_start();
      a_pulses(0, 144, 0);
      check("ovf_not_yet", 32'(ifa.o_err), 32'd0);
      a_pulses(0, 1, 0);
      check("ovf_code2", 32'({ifa.o_err, ifa.o_err_code}), 32'b110);
      a_clr();
      a_start();
      a_pulses(0, 144, 0);
      ifa.i_pool_valid = 1;
      a_cls(8'h11);
      ifa.i_pool_valid = 0;
      check("ovf_beats_early", 32'({ifa.o_err, ifa.o_err_code}), 32'b110);
      a_clr();

      // watchdog
      a_start();
      repeat (4095) cyc();
      check("tmo_4095_quiet", 32'(ifa.o_err), 32'd0);
      cyc();
      check("tmo_4096", 32'({ifa.o_err, ifa.o_err_code}), 32'b111);
      a_clr();
      a_start();
      repeat (4094) cyc();
      a_pulses(1, 0, 0);
      check("tmo_saved", 32'({ifa.o_err, ifa.o_busy}), 32'b01);
      repeat (10) cyc();
      check("tmo_saved_later", 32'({ifa.o_err, ifa.o_busy}), 32'b01);

      // reset mid-frame, stray valids in IDLE, then a clean frame
      rst_n_a = 0;
      cyc();
      rst_n_a = 1;
      a_start();
      a_pulses(300, 0, 0);
      rst_n_a = 0;
      cyc();
      rst_n_a = 1;
      check("midrst_outs", 32'({ifa.o_feed_start, ifa.o_busy, ifa.o_done, ifa.o_err, ifa.o_err_code}), 32'd0);
      check("midrst_alpha_frames", 32'({ifa.o_alpha, ifa.o_frame_cnt}), 32'd0);
      a_pulses(7, 7, 7);
      check("stray_idle", 32'({ifa.o_busy, ifa.o_err, ifa.o_start_ready}), 32'b001);
      a_start();
      a_pulses(576, 144, 64);
      a_cls(8'h43);
      check("post_rst_frame", 32'({ifa.o_done, ifa.o_alpha, 16'(ifa.o_frame_cnt)}), {7'd0, 1'b1, 8'h43, 16'd1});
      cyc();

      // frame counter wrap on the narrow instance
      rst_n_b = 1;
      for (int f = 1; f <= 4; f++) begin
         b_frame(8'(f));
         check($sformatf("wrap_frame%0d", f), 32'({ifb.o_done, ifb.o_frame_cnt}), 32'({1'b1, 2'(f)}));
         cyc();
      end

      // random traffic against the reference model
      for (int it = 0; it < 3000; it++) begin
         rst  = !((it == 0) || ($urandom_range(0, 199) == 0));
         full = (m_cnt[0] == m_tgt[0]) && (m_cnt[1] == m_tgt[1]) && (m_cnt[2] == m_tgt[2]);
         for (int k = 0; k < 3; k++)
            rv[k] = (m_cnt[k] < m_tgt[k]) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
         cl  = full ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         st  = ($urandom_range(0, 3) == 0);
         clr = ($urandom_range(0, 3) == 0);
         al  = 8'($urandom);
         rst_n_b = rst;
         ifb.i_start = st; ifb.i_err_clr = clr; ifb.i_cls_valid = cl; ifb.i_cls_alpha = al;
         ifb.i_conv1_valid = rv[0]; ifb.i_pool_valid = rv[1]; ifb.i_st2_valid = rv[2];
         cyc();
         model_step(rst, st, rv, cl, al, clr);
         act = {ifb.o_start_ready, ifb.o_feed_start, ifb.o_busy, ifb.o_done, ifb.o_err,
                ifb.o_err_code, ifb.o_alpha, ifb.o_frame_cnt};
         check($sformatf("rand_cycle%0d", it), 32'(act), 32'(model_out()));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_n, miscmp);
      $finish;
   end
endmodule
